// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared constants and FSM state encoding for bus_arbiter
// Purpose: reset/write-enable constants, zero word, byte-enable mask and the
//          3-bit arbiter state type used by bus_arbiter.
// Ports:   none (package)
package bus_arbiter_pkg;

  localparam logic        RST_ENABLE    = 1'b1;
  localparam logic        RST_DISABLE   = 1'b0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [3:0]  SEL_ALL       = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DBUSY = 3'd1,
    ST_IBUSY = 3'd2,
    ST_DDONE = 3'd3,
    ST_IDONE = 3'd4
  } state_e;

endpackage

// File: rtl/bus_arbiter_timer.sv
// rtl/bus_arbiter_timer.sv - busy-state timeout counter for bus_arbiter
// Purpose: counts busy cycles; expired_o flags the busy cycle whose increment
//          would bring the count to TIMEOUT_CYCLES, so the access is
//          force-completed on the edge that ends that cycle.
// Ports:   clk, rst    clock, synchronous active-high reset
//          clr_i       zero the counter (wins over en_i)
//          en_i        count this cycle
//          expired_o   timeout reached in the current counting cycle
module bus_timer
  import bus_arbiter_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Comparing against TIMEOUT_CYCLES-1 means exactly TIMEOUT_CYCLES busy
  // cycles elapse before the forced completion.
  assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - fetch/data arbiter onto one single-port bus with timeout
// Purpose: serialises IF fetches and MEM loads/stores onto one req/ack bus,
//          data first; returns registered read data and per-requester stalls.
// Ports:   clk, rst                          clock, sync active-high reset
//          if_ce_i/if_addr_i                 fetch request
//          if_data_o, if_stallreq_o          fetched word, fetch stall
//          mem_ce_i/we/sel/addr/data_i       data request
//          mem_data_o, mem_stallreq_o        load data, data stall
//          flush_i                           drop the in-flight fetch result
//          bus_req/we/sel/addr/wdata_o       registered bus request
//          bus_ack_i, bus_rdata_i            bus completion and read data
//          bus_err_o                         one-cycle pulse on timeout
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_stallreq_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_stallreq_o,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_err_o
);

  state_e      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        bus_err_q, bus_err_d;
  logic        discard_q, discard_d;

  logic busy;
  logic expired;
  logic done_evt;

  assign busy     = (state_q == ST_DBUSY) || (state_q == ST_IBUSY);
  // An ack in the same cycle as expiry counts as a normal completion.
  assign done_evt = busy && (bus_ack_i || expired);

  bus_timer #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (!busy || done_evt),
    .en_i      (busy),
    .expired_o (expired)
  );

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_data_d   = if_data_q;
    mem_data_d  = mem_data_q;
    bus_err_d   = 1'b0;
    discard_d   = discard_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_ce_i) begin
          state_d     = ST_DBUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_sel_d   = mem_sel_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_data_i;
        end else if (if_ce_i) begin
          state_d     = ST_IBUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = WRITE_DISABLE;
          bus_sel_d   = SEL_ALL;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = ZERO_WORD;
          if (flush_i) discard_d = 1'b1;
        end
      end
      ST_DBUSY: begin
        if (done_evt) begin
          state_d   = ST_DDONE;
          bus_req_d = 1'b0;
          bus_err_d = !bus_ack_i;
          if (bus_we_q != WRITE_ENABLE) begin
            mem_data_d = bus_ack_i ? bus_rdata_i : ZERO_WORD;
          end
        end
      end
      ST_IBUSY: begin
        if (flush_i) discard_d = 1'b1;
        if (done_evt) begin
          bus_req_d = 1'b0;
          bus_err_d = !bus_ack_i;
          // A flushed fetch skips IDONE so the requester never sees a
          // non-stalled cycle for the stale instruction.
          if (discard_q || flush_i) begin
            state_d   = ST_IDLE;
            discard_d = 1'b0;
          end else begin
            state_d   = ST_IDONE;
            if_data_d = bus_ack_i ? bus_rdata_i : ZERO_WORD;
          end
        end
      end
      ST_DDONE, ST_IDONE: state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= WRITE_DISABLE;
      bus_sel_q   <= 4'b0000;
      bus_addr_q  <= ZERO_WORD;
      bus_wdata_q <= ZERO_WORD;
      if_data_q   <= ZERO_WORD;
      mem_data_q  <= ZERO_WORD;
      bus_err_q   <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_data_q   <= if_data_d;
      mem_data_q  <= mem_data_d;
      bus_err_q   <= bus_err_d;
      discard_q   <= discard_d;
    end
  end

  assign mem_stallreq_o = mem_ce_i && (state_q != ST_DDONE);
  assign if_stallreq_o  = if_ce_i && (state_q != ST_IDONE);

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign if_data_o   = if_data_q;
  assign mem_data_o  = mem_data_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter
module tb_bus_arbiter;

  localparam logic [31:0] FETCH0 = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_ce = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_data;
  logic        if_stall;
  logic        mem_ce = 1'b0;
  logic        mem_we = 1'b0;
  logic [3:0]  mem_sel = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_data;
  logic        mem_stall;
  logic        flush = 1'b0;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;

  bus_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce), .if_addr_i(if_addr), .if_data_o(if_data), .if_stallreq_o(if_stall),
    .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
    .mem_data_i(mem_wdata), .mem_data_o(mem_data), .mem_stallreq_o(mem_stall),
    .flush_i(flush),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_sel_o(bus_sel), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({bus_req, bus_we, bus_sel, bus_err} !== 7'd0) begin
      n_err++; $display("FAIL reset_ctrl got %b want 0", {bus_req, bus_we, bus_sel, bus_err});
    end
    n_vec++;
    if ({bus_addr, bus_wdata} !== 64'd0) begin
      n_err++; $display("FAIL reset_addr_wdata got %h want 0", {bus_addr, bus_wdata});
    end
    n_vec++;
    if ({if_data, mem_data} !== 64'd0) begin
      n_err++; $display("FAIL reset_data got %h want 0", {if_data, mem_data});
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    int req_cnt = 0;
    int low_cnt = 0;
    int low_at = -1;
    mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hf; mem_addr = 32'h100; mem_wdata = '0;
    exp_q.push_back(32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus_req) req_cnt++;
      if (i == 0) begin
        n_vec++;
        if ({bus_we, bus_addr} !== {1'b0, 32'h100}) begin
          n_err++; $display("FAIL load_issue got we=%b addr=%h want 0/100", bus_we, bus_addr);
        end
      end
      if (!mem_stall) begin
        low_cnt++; low_at = i;
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        n_vec++;
        if (mem_data !== exp_w) begin
          n_err++; $display("FAIL load_data got %h want %h", mem_data, exp_w);
        end
      end
      bus_ack   = (i == 2);
      bus_rdata = (i == 2) ? 32'hDEADBEEF : 32'h0;
      if (i == 4) mem_ce = 1'b0;
    end
    n_vec++;
    if (req_cnt !== 3) begin n_err++; $display("FAIL load_req_cycles got %0d want 3", req_cnt); end
    n_vec++;
    if (low_cnt !== 1 || low_at !== 3) begin
      n_err++; $display("FAIL load_stall_low got count=%0d at=%0d want 1 at 3", low_cnt, low_at);
    end
  endtask

  task automatic test_priority();
    int store_ack = -1;
    int fetch_req = -1;
    int if_low_early = 0;
    bit seen_store = 0;
    bit mem_done = 0;
    bit if_done = 0;
    if_ce = 1'b1; if_addr = 32'h0;
    mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h200; mem_wdata = 32'h12345678;
    exp_q.push_back(FETCH0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus_req && !seen_store) begin
        seen_store = 1;
        n_vec++;
        if ({bus_we, bus_sel, bus_addr, bus_wdata} !== {1'b1, 4'b0011, 32'h200, 32'h12345678}) begin
          n_err++; $display("FAIL prio_store_issue got we=%b sel=%b addr=%h wdata=%h want 1/0011/200/12345678",
                            bus_we, bus_sel, bus_addr, bus_wdata);
        end
      end
      if (mem_ce && !if_stall) if_low_early++;
      if (mem_ce && !mem_stall) begin mem_done = 1; mem_ce = 1'b0; end
      if (mem_done && fetch_req < 0 && bus_req) begin
        fetch_req = i;
        n_vec++;
        if ({bus_we, bus_sel, bus_addr, bus_wdata} !== {1'b0, 4'b1111, 32'h0, 32'h0}) begin
          n_err++; $display("FAIL prio_fetch_issue got we=%b sel=%b addr=%h wdata=%h want 0/1111/0/0",
                            bus_we, bus_sel, bus_addr, bus_wdata);
        end
      end
      if (if_ce && !if_stall) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        n_vec++;
        if (if_data !== exp_w) begin n_err++; $display("FAIL prio_fetch_data got %h want %h", if_data, exp_w); end
        if_ce = 1'b0; if_done = 1;
      end
      if (bus_req && store_ack < 0 && fetch_req < 0) store_ack = i;
      bus_ack   = bus_req;
      bus_rdata = (fetch_req >= 0) ? FETCH0 : 32'h0;
    end
    n_vec++;
    if (!mem_done || !if_done) begin
      n_err++; $display("FAIL prio_completion got store=%0d fetch=%0d want 1 1", mem_done, if_done);
    end
    n_vec++;
    if (if_low_early !== 0) begin
      n_err++; $display("FAIL prio_if_stall got %0d low cycles during store want 0", if_low_early);
    end
    // Ack in cycle a, DDONE a+1, IDLE a+2 latches the fetch, bus_req seen a+3.
    n_vec++;
    if (store_ack < 0 || fetch_req !== store_ack + 3) begin
      n_err++; $display("FAIL prio_fetch_gap got store_ack=%0d fetch_req=%0d want fetch=store+3", store_ack, fetch_req);
    end
    n_vec++;
    if (mem_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL prio_store_keeps_mem_data got %h want deadbeef", mem_data);
    end
  endtask

  task automatic test_flush();
    if_ce = 1'b1; if_addr = 32'h40;
    tick();
    n_vec++;
    if (bus_req !== 1'b1) begin n_err++; $display("FAIL flush_issue got req=%b want 1", bus_req); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hAAAA5555;
    tick();
    bus_ack = 1'b0;
    n_vec++;
    if ({if_stall, bus_req, bus_err} !== 3'b100) begin
      n_err++; $display("FAIL flush_after_ack got stall/req/err=%b want 100", {if_stall, bus_req, bus_err});
    end
    n_vec++;
    if (if_data !== FETCH0) begin n_err++; $display("FAIL flush_if_data got %h want %h", if_data, FETCH0); end
    if_ce = 1'b0;
    tick();
    n_vec++;
    if ({bus_req, if_data} !== {1'b0, FETCH0}) begin
      n_err++; $display("FAIL flush_idle got req=%b data=%h want 0/%h", bus_req, if_data, FETCH0);
    end
  endtask

  task automatic test_timeout();
    int req_cnt = 0;
    int err_cnt = 0;
    int err_at = -1;
    mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hf; mem_addr = 32'h300;
    bus_ack = 1'b0;
    exp_q.push_back(32'h0);
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus_req) req_cnt++;
      if (bus_err) begin
        err_cnt++; err_at = i;
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        n_vec++;
        if ({mem_data, bus_req, mem_stall} !== {exp_w, 1'b0, 1'b0}) begin
          n_err++; $display("FAIL timeout_result got data=%h req=%b stall=%b want %h/0/0", mem_data, bus_req, mem_stall, exp_w);
        end
      end
      if (mem_ce && !mem_stall) mem_ce = 1'b0;
    end
    n_vec++;
    if (req_cnt !== 4) begin n_err++; $display("FAIL timeout_busy_cycles got %0d want 4", req_cnt); end
    n_vec++;
    if (err_cnt !== 1 || err_at !== 4) begin
      n_err++; $display("FAIL timeout_err_pulse got count=%0d at=%0d want 1 at 4", err_cnt, err_at);
    end
  endtask

  task automatic test_reset_mid();
    mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hf; mem_addr = 32'h400;
    tick();
    n_vec++;
    if (bus_req !== 1'b1) begin n_err++; $display("FAIL rstmid_issue got req=%b want 1", bus_req); end
    rst = 1'b1;
    tick();
    n_vec++;
    if ({bus_req, bus_we, bus_sel, bus_err, bus_addr, bus_wdata, if_data, mem_data} !== '0) begin
      n_err++; $display("FAIL rstmid_outputs got req=%b addr=%h if=%h mem=%h want all 0", bus_req, bus_addr, if_data, mem_data);
    end
    rst = 1'b0; mem_ce = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h77777777;
    tick();
    bus_ack = 1'b0;
    n_vec++;
    if ({bus_req, bus_err, mem_data} !== {2'b00, 32'h0}) begin
      n_err++; $display("FAIL rstmid_late_ack got req=%b err=%b mem=%h want 0/0/0", bus_req, bus_err, mem_data);
    end
    tick();
    n_vec++;
    if ({bus_req, mem_data} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL rstmid_settled got req=%b mem=%h want 0/0", bus_req, mem_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    int issued = 0;
    int done = 0;
    int last_low = -1;
    int gap_bad = 0;
    words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
    if_ce = 1'b1; if_addr = 32'h1000;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus_req && issued < 3) begin
        n_vec++;
        if (bus_addr !== 32'h1000 + 32'(4 * issued)) begin
          n_err++; $display("FAIL b2b_addr got %h want %h", bus_addr, 32'h1000 + 32'(4 * issued));
        end
        exp_q.push_back(words[issued]);
        bus_rdata = words[issued];
        issued++;
      end
      bus_ack = bus_req;
      if (if_ce && !if_stall) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        n_vec++;
        if (if_data !== exp_w) begin n_err++; $display("FAIL b2b_data got %h want %h", if_data, exp_w); end
        if (last_low >= 0 && i - last_low != 3) gap_bad++;
        last_low = i;
        done++;
        if_addr = if_addr + 32'd4;
        if (done == 3) if_ce = 1'b0;
      end
    end
    bus_ack = 1'b0;
    n_vec++;
    if (done !== 3 || gap_bad !== 0) begin
      n_err++; $display("FAIL b2b_rate got done=%0d bad_gaps=%0d want 3/0", done, gap_bad);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_priority();
    test_flush();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
